key_filter: RTL and testbench
=============================

// Module: key_filter
// PURPOSE
//   Debounce stage placed directly upstream of flip_flops: turns a raw, bouncing,
//   asynchronous push-button level into a clean, synchronous key_out level (drives
//   flip_flops.key_in) plus a one-cycle press pulse key_flag.
//   Contains a 2-FF synchronizer, a 4-state debounce FSM and a hold/long-press counter.
// PARAMETERS
//   CNT_MAX    999_999     debounce window minus 1, in sys_clk cycles (20 ms @ 50 MHz)
//   LONG_MAX   49_999_999  PRESSED-state cycles before key_long fires (1 s @ 50 MHz)
//   KEY_ACTIVE 1'b0        raw key_in level meaning "pressed" (board keys are active-low)
// PORTS
//   sys_clk    in   1  system clock, 50 MHz; all logic on its rising edge
//   sys_rst    in   1  reset, synchronous, active-high
//   key_in     in   1  raw asynchronous button level
//   key_out    out  1  debounced level, 1 = pressed
//   key_flag   out  1  1-cycle pulse on each debounced press
//   key_long   out  1  1-cycle pulse once per press held LONG_MAX cycles (see CONFIGURATION)
// BEHAVIOUR
//   Clocking/reset: one clock; reset is synchronous and active-high.
//   - Reset (sys_rst=1 at an edge): sync FFs <= ~KEY_ACTIVE, state <= IDLE, counters <= 0,
//     key_out=0, key_flag=0, key_long=0. Applies mid-press as well: no pulse
//     issued on the reset edge.
//   Sync: s1 <= key_in; s2 <= s1. key_lvl = (s2 == KEY_ACTIVE). FSM only sees key_lvl.
//   Counters: cnt width $clog2(CNT_MAX+1); long_cnt width $clog2(LONG_MAX+1).
//   FSM (one transition per edge):
//   - IDLE:        key_lvl=1 -> PRESS_CHK, cnt<=0. Else stay.
//   - PRESS_CHK:   key_lvl=0 -> IDLE (bounce rejected, no output change).
//                  key_lvl=1 and cnt<CNT_MAX -> cnt++.
//                  key_lvl=1 and cnt==CNT_MAX -> PRESSED, key_out<=1, key_flag<=1,
//                  long_cnt<=0.
//   - PRESSED:     key_lvl=0 -> RELEASE_CHK, cnt<=0. Else long_cnt++ (saturates at LONG_MAX).
//   - RELEASE_CHK: key_lvl=1 -> PRESSED (release bounce; long_cnt held).
//                  key_lvl=0, cnt<CNT_MAX -> cnt++.
//                  key_lvl=0, cnt==CNT_MAX -> IDLE, key_out<=0.
//   Outputs are registered. key_flag is high exactly one cycle: the cycle after
//   entering PRESSED.
//   Latency: key_in active ahead of edge E0 and held -> key_out/key_flag high after edge
//   E0+CNT_MAX+3 (2 sync + 1 IDLE->PRESS_CHK + CNT_MAX count). Release symmetric for key_out.
//   Boundaries: glitch shorter than CNT_MAX+1 cycles of key_lvl never reaches key_out;
//   key_flag one per debounced press, never on release or on a RELEASE_CHK->PRESSED return;
//   counters never wrap.
// CONFIGURATION
//   Macro KEY_FILTER_LONG_PRESS_EN:
//   - defined: in PRESSED, when long_cnt reaches LONG_MAX, key_long pulses 1 cycle;
//     fires at most once per press (re-armed only via PRESS_CHK->PRESSED).
//   - undefined: long_cnt logic removed; key_long tied to 1'b0; other behaviour unchanged.
// TESTING (bench params CNT_MAX=4, LONG_MAX=20, KEY_ACTIVE=0, 20 ns clock)
//   1 Reset: sys_rst=1 for 2 edges, key_in=0 -> key_out=0, key_flag=0, key_long=0
//     throughout reset.
//   2 Clean press: key_in 1->0 before E0, held -> key_flag=1 for exactly one cycle
//     after E7, key_out=1 from E7.
//   3 Bounce: key_in low 3 cycles then high, repeat 5x -> key_out stays 0, key_flag never 1.
//   4 Release: from PRESSED, key_in->1 held -> key_out falls after E7 of release;
//     a 2-cycle high glitch mid-hold -> key_out stays 1, no second key_flag.
//   5 Long press (macro on): hold 40 cycles -> single key_long pulse 21 PRESSED cycles
//     after key_flag; macro off -> key_long=0.
//   6 Reset mid-press: sys_rst=1 while PRESSED -> key_out=0 next edge; after release
//     of reset with key still held, new key_flag after 7 edges.

Source files
------------

// File: rtl/key_filter.sv
// Push-button debounce: 2-FF synchronizer, 4-state debounce FSM, press pulse and
// optional long-press pulse (enabled by defining KEY_FILTER_LONG_PRESS_EN).
module key_filter #(
    parameter int unsigned CNT_MAX    = 999_999,
    parameter int unsigned LONG_MAX   = 49_999_999,
    parameter logic        KEY_ACTIVE = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_out,
    output logic key_flag,
    output logic key_long
);

    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    logic             key_out_q, key_out_d;
    logic             key_flag_q, key_flag_d;
    logic             key_lvl;

`ifdef KEY_FILTER_LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_MAX + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX);

    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_done_q, long_done_d;
    logic              key_long_q, key_long_d;
`endif

    assign key_lvl = (sync2_q == KEY_ACTIVE);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_out_d  = key_out_q;
        key_flag_d = 1'b0;
`ifdef KEY_FILTER_LONG_PRESS_EN
        long_cnt_d  = long_cnt_q;
        long_done_d = long_done_q;
        key_long_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (key_lvl) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!key_lvl) begin
                    state_d = IDLE;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d    = PRESSED;
                    key_out_d  = 1'b1;
                    key_flag_d = 1'b1;
`ifdef KEY_FILTER_LONG_PRESS_EN
                    long_cnt_d  = '0;
                    long_done_d = 1'b0;
`endif
                end
            end
            PRESSED: begin
                if (!key_lvl) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
`ifdef KEY_FILTER_LONG_PRESS_EN
                else if (long_cnt_q != LONG_LAST) begin
                    long_cnt_d = long_cnt_q + LONG_W'(1);
                end else if (!long_done_q) begin
                    // Counter sits saturated; long_done keeps this to one pulse per press.
                    key_long_d  = 1'b1;
                    long_done_d = 1'b1;
                end
`endif
            end
            RELEASE_CHK: begin
                if (key_lvl) begin
                    state_d = PRESSED;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d   = IDLE;
                    key_out_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q    <= ~KEY_ACTIVE;
            sync2_q    <= ~KEY_ACTIVE;
            state_q    <= IDLE;
            cnt_q      <= '0;
            key_out_q  <= 1'b0;
            key_flag_q <= 1'b0;
`ifdef KEY_FILTER_LONG_PRESS_EN
            long_cnt_q  <= '0;
            long_done_q <= 1'b0;
            key_long_q  <= 1'b0;
`endif
        end else begin
            sync1_q    <= key_in;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_out_q  <= key_out_d;
            key_flag_q <= key_flag_d;
`ifdef KEY_FILTER_LONG_PRESS_EN
            long_cnt_q  <= long_cnt_d;
            long_done_q <= long_done_d;
            key_long_q  <= key_long_d;
`endif
        end
    end

    assign key_out  = key_out_q;
    assign key_flag = key_flag_q;
`ifdef KEY_FILTER_LONG_PRESS_EN
    assign key_long = key_long_q;
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter: run-length reference model compared every cycle,
// plus literal latency checks. Honours KEY_FILTER_LONG_PRESS_EN like the design.
module tb_key_filter;

    localparam int CNT_MAX  = 4;
    localparam int LONG_MAX = 20;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_in  = 1'b1;
    logic key_out, key_flag, key_long;

    key_filter #(
        .CNT_MAX   (CNT_MAX),
        .LONG_MAX  (LONG_MAX),
        .KEY_ACTIVE(1'b0)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_in  (key_in),
        .key_out (key_out),
        .key_flag(key_flag),
        .key_long(key_long)
    );

    always #10 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: debounced level flips after CNT_MAX+2 consecutive samples
    // of the opposite level; long pulse on the (LONG_MAX+1)-th held edge in PRESSED.
    logic m_s1 = 1'b1, m_s2 = 1'b1, m_deb = 1'b0;
    int   m_run = 0, m_zrun = 0, m_n = 0;
    logic exp_out = 1'b0, exp_flag = 1'b0, exp_long = 1'b0;

    // Event bookkeeping relative to a test mark
    int edge_idx, flag_at, long_at, fall_at;
    int dut_flags, dut_longs, dut_out_hi;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0b want %0b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic kin);
        logic lvl;
        logic prev_out;
        prev_out = exp_out;
        exp_flag = 1'b0;
        exp_long = 1'b0;
        if (rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b0;
            m_run = 0; m_zrun = 0; m_n = 0;
        end else begin
            lvl  = (m_s2 == 1'b0);
            m_s2 = m_s1;
            m_s1 = kin;
            if (!m_deb) begin
                m_run = lvl ? m_run + 1 : 0;
                if (m_run == CNT_MAX + 2) begin
                    m_deb = 1'b1; exp_flag = 1'b1;
                    m_run = 0; m_zrun = 0; m_n = 0;
                end
            end else begin
                if (!lvl) begin
                    m_zrun++;
                end else begin
                    if (m_zrun == 0) begin
                        m_n++;
`ifdef KEY_FILTER_LONG_PRESS_EN
                        if (m_n == LONG_MAX + 1) exp_long = 1'b1;
`endif
                    end
                    m_zrun = 0;
                end
                if (m_zrun == CNT_MAX + 2) begin
                    m_deb = 1'b0; m_run = 0; m_zrun = 0;
                end
            end
        end
        exp_out = m_deb;
        if (exp_flag) flag_at = edge_idx;
        if (exp_long) long_at = edge_idx;
        if (prev_out && !exp_out) fall_at = edge_idx;
    endtask

    task automatic mark();
        edge_idx = 0; flag_at = -1; long_at = -1; fall_at = -1;
        dut_flags = 0; dut_longs = 0; dut_out_hi = 0;
    endtask

    // One clock: apply inputs, advance model on the edge, compare 1 ns later.
    task automatic step(input logic rst, input logic kin);
        sys_rst = rst;
        key_in  = kin;
        @(posedge sys_clk);
        model_edge(rst, kin);
        #1;
        check("key_out", key_out, exp_out);
        check("key_flag", key_flag, exp_flag);
        check("key_long", key_long, exp_long);
        if (key_flag === 1'b1) dut_flags++;
        if (key_long === 1'b1) dut_longs++;
        if (key_out === 1'b1) dut_out_hi++;
        edge_idx++;
    endtask

    initial begin
        mark();

        // 1: reset with key held at pressed level
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("rst_out", key_out, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);

        // 2: clean press, flag exactly at E7
        mark();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        check_int("press_latency", flag_at, 7);
        check_int("press_flags", dut_flags, 1);

        // 4a: 2-cycle release glitch while pressed
        mark();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        check_int("glitch_flags", dut_flags, 0);
        check_int("glitch_out_hi", dut_out_hi, 12);

        // 4b: clean release, key_out falls at E7
        mark();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        check_int("release_latency", fall_at, 7);
        check_int("release_flags", dut_flags, 0);

        // 3: bounce, 3 low / 3 high five times
        mark();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
            for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        check_int("bounce_flags", dut_flags, 0);
        check_int("bounce_out_hi", dut_out_hi, 0);

        // 5: long press held 40 cycles
        mark();
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
        check_int("long_flag_at", flag_at, 7);
`ifdef KEY_FILTER_LONG_PRESS_EN
        check_int("long_delay", long_at - flag_at, 21);
        check_int("long_pulses", dut_longs, 1);
`else
        check_int("long_pulses_off", dut_longs, 0);
`endif
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

        // 6: reset while pressed, then re-press with key still held
        mark();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        check("pre_rst_out", key_out, 1'b1);
        step(1'b1, 1'b0);
        check("mid_rst_out", key_out, 1'b0);
        check("mid_rst_flag", key_flag, 1'b0);
        mark();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        check_int("repress_latency", flag_at, 7);
        check_int("repress_flags", dut_flags, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
